// File: rtl/regfile_mp.sv
// Multi-ported register file with zero register, per-register busy scoreboard,
// flush, optional same-cycle write-to-read forwarding and synchronous reset.
module regfile_mp #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NREAD  = 4,
  parameter int unsigned NWRITE = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NWRITE-1:0]       w_en,
  input  logic [NWRITE*AW-1:0]    w_addr,
  input  logic [NWRITE*WIDTH-1:0] w_data,
  input  logic [NREAD*AW-1:0]     r_addr,
  output logic [NREAD*WIDTH-1:0]  r_data,
  output logic [NREAD-1:0]        r_busy,
  input  logic                    alloc_en,
  input  logic [AW-1:0]           alloc_addr,
  input  logic                    flush
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Register 0 and addresses beyond DEPTH are neither stored nor tracked.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < DEPTH);
  endfunction

  // Busy update priority: write clears, alloc sets, flush clears everything.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < int'(NWRITE); k++) begin
      if (w_en[k] && addr_ok(w_addr[k*AW +: AW])) begin
        busy_nxt[w_addr[k*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en && addr_ok(alloc_addr)) begin
      busy_nxt[alloc_addr] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
  end

  // Later write ports are applied last, so the highest index wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int k = 0; k < int'(NWRITE); k++) begin
        if (w_en[k] && addr_ok(w_addr[k*AW +: AW])) begin
          regs[w_addr[k*AW +: AW]] <= w_data[k*WIDTH +: WIDTH];
        end
      end
      busy <= busy_nxt;
    end
  end

  // Asynchronous read ports with optional forwarding of in-flight write data.
  always_comb begin
    r_data = '0;
    r_busy = '0;
    for (int j = 0; j < int'(NREAD); j++) begin
      if (addr_ok(r_addr[j*AW +: AW])) begin
        r_data[j*WIDTH +: WIDTH] = regs[r_addr[j*AW +: AW]];
        r_busy[j]                = busy[r_addr[j*AW +: AW]];
        if (BYPASS != 0) begin
          for (int k = 0; k < int'(NWRITE); k++) begin
            if (w_en[k] && (w_addr[k*AW +: AW] == r_addr[j*AW +: AW])) begin
              r_data[j*WIDTH +: WIDTH] = w_data[k*WIDTH +: WIDTH];
              r_busy[j]                = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, register count; legal range 2..64.
REQ-003 SHALL have parameter NREAD, default 4, number of async read ports.
REQ-004 SHALL have parameter NWRITE, default 2, number of sync write ports.
REQ-005 SHALL have parameter BYPASS, default 1, where 1 forwards same-cycle write data to reads.
REQ-006 SHALL derive AW = clog2(DEPTH) as the address width.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-009 SHALL have port w_en, input, NWRITE, per-port write enable.
REQ-010 SHALL have port w_addr, input, NWRITE*AW, packed write addresses; port k occupies bits [k*AW +: AW].
REQ-011 SHALL have port w_data, input, NWRITE*WIDTH, packed write data.
REQ-012 SHALL have port r_addr, input, NREAD*AW, packed read addresses.
REQ-013 SHALL have port r_data, output, NREAD*WIDTH, packed read data.
REQ-014 SHALL have port r_busy, output, NREAD, per-read-port pending-write (busy) flag.
REQ-015 SHALL have port alloc_en, input, 1, marks alloc_addr busy (destination allocated, result pending).
REQ-016 SHALL have port alloc_addr, input, AW, register to mark busy.
REQ-017 SHALL have port flush, input, 1, clears all busy bits; data is retained.

Function
REQ-018 SHALL hold register 0 at constant zero: writes to it are ignored, it is never busy, and reads of it return 0 with r_busy=0.
REQ-019 SHALL update a register at the rising edge on which the corresponding w_en bit is high; write latency is 1 cycle.
REQ-020 SHALL apply only the highest-indexed port when several enabled write ports target the same address in one cycle.
REQ-021 SHALL drive r_data combinationally from the register selected by r_addr, independently per port.
REQ-022 SHALL, when BYPASS=1 and an enabled write targets a read port's address in the same cycle, return that write's data on the read port (highest-indexed write wins) and drive r_busy=0.
REQ-023 SHALL, when BYPASS=0, return only stored values on reads; same-cycle write data becomes visible on the next cycle.
REQ-024 SHALL set busy[alloc_addr] at the edge on which alloc_en=1.
REQ-025 SHALL clear busy[a] at the edge on which any enabled write targets a.
REQ-026 SHALL leave busy[a]=1 when alloc and write target the same a in the same cycle (alloc wins); the data is still written.
REQ-027 SHALL clear every busy bit at the edge on which flush=1; a same-cycle alloc is discarded (flush wins), while same-cycle writes still update data.
REQ-028 SHALL ignore writes and allocs to addresses >= DEPTH (non-power-of-2 DEPTH); reads of such addresses SHALL return 0 with r_busy=0.
REQ-029 SHALL drive r_busy from the stored busy bit, subject to REQ-022 and REQ-028.

Reset
REQ-030 SHALL, at the edge on which reset=1, clear all registers to 0 and all busy bits to 0, overriding same-cycle writes, allocs and flush.
REQ-031 SHALL, after reset, read 0 with r_busy=0 on every read port.

Verification
REQ-032 SHALL cover write port 0 writing addr 5 = 0xDEADBEEF, then reading addr 5 on all ports the next cycle -> 0xDEADBEEF on every port.
REQ-033 SHALL cover ports 0 and 1 writing addr 7 with 0x11 and 0x22 in the same cycle -> next-cycle read of addr 7 returns 0x22.
REQ-034 SHALL cover, with BYPASS=1, a write to addr 3 = 0xA5 while read port 2 reads addr 3 -> r_data[2]=0xA5 in the same cycle; with BYPASS=0 the same stimulus returns the old value 0.
REQ-035 SHALL cover alloc of addr 9 -> r_busy=1 on the next cycle; a write to addr 9 then clears it; a same-cycle alloc+write to addr 9 leaves it busy.
REQ-036 SHALL cover allocs of addrs 4 and 6 followed by flush together with alloc of addr 8 -> all busy=0 with data unchanged; also a write of 0x55 to addr 0 -> a read of addr 0 returns 0.
REQ-037 SHALL cover reset asserted mid-run, coincident with a write to addr 2 -> next cycle addr 2 reads 0 and all busy bits are 0.
